// File: rtl/mem_unit_sized.sv
// Byte-addressed data memory with byte/half/word accesses, alignment checking,
// a req/ready request channel and a valid response after WAIT wait states.
module mem_unit_sized #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13,
    parameter int WAIT   = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    output logic              ready_o,
    input  logic              wr_i,
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              err_o
);
    // state   | meaning
    // IDLE    | no response pending, request accepted
    // WAIT    | wait states counting down, requests ignored
    // RESP    | response presented for one cycle, next request accepted

    localparam int NB    = DATA_W / 8;
    localparam int LB    = $clog2(NB);
    localparam int DEPTH = 1 << (ADDR_W - LB);
    localparam logic [3:0] WAIT_M1 = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t state, next_state;
    logic [3:0] cnt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic                 accept;
    logic                 req_err;
    logic                 resp_load;
    logic [ADDR_W-LB-1:0] word_idx;
    logic [LB-1:0]        lane;
    logic [LB-1:0]        size_mask;
    logic [NB-1:0]        byte_en;
    logic [DATA_W-1:0]    bit_mask;
    logic [DATA_W-1:0]    rd_word;
    logic [DATA_W-1:0]    wr_data;
    logic [DATA_W-1:0]    resp_data_next;
    logic                 resp_err_next;

    logic [DATA_W-1:0]    hold_q;
    logic [LB-1:0]        lane_q;
    logic [1:0]           size_q;
    logic                 sgn_q;
    logic                 wr_q;
    logic                 err_q;

    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] word,
                                                  input logic [LB-1:0]     ln,
                                                  input logic [1:0]        sz,
                                                  input logic              sgn);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] keep;
        logic [DATA_W-1:0] top;
        int                nbits;
        sh    = word >> {ln, 3'b000};
        nbits = 8 << sz;
        if (nbits > DATA_W)
            nbits = DATA_W;
        keep = {DATA_W{1'b1}} >> (DATA_W - nbits);
        top  = sh >> (nbits - 1);
        return (sh & keep) | ((sgn && top[0]) ? ~keep : '0);
    endfunction

    assign word_idx  = addr_i[ADDR_W-1:LB];
    assign lane      = addr_i[LB-1:0];
    assign size_mask = ~({LB{1'b1}} << size_i);
    assign req_err   = (int'(size_i) > LB) || ((lane & size_mask) != '0);
    assign byte_en   = ~({NB{1'b1}} << (1 << size_i)) << lane;
    assign wr_data   = data_i << {lane, 3'b000};
    assign rd_word   = mem[word_idx];
    assign accept    = req_i && ready_o;

    for (genvar g = 0; g < NB; g++) begin : g_mask
        assign bit_mask[8*g +: 8] = {8{byte_en[g]}};
    end

    // With no wait states the response is formed at the acceptance edge itself,
    // so it must come straight from the array rather than the holding register.
    assign resp_load = (WAIT == 0) ? accept : (state == ST_WAIT && cnt == 4'd0);

    always_comb begin
        resp_err_next  = 1'b0;
        resp_data_next = '0;
        if (WAIT == 0) begin
            resp_err_next = req_err;
            if (!req_err && !wr_i)
                resp_data_next = extract(rd_word, lane, size_i, signed_i);
        end else begin
            resp_err_next = err_q;
            if (!err_q && !wr_q)
                resp_data_next = extract(hold_q, lane_q, size_q, sgn_q);
        end
    end

    // Array has no reset; stores commit at the acceptance edge.
    always_ff @(posedge clk_i) begin
        if (accept && wr_i && !req_err)
            mem[word_idx] <= (rd_word & ~bit_mask) | (wr_data & bit_mask);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            hold_q <= '0;
            lane_q <= '0;
            size_q <= 2'd0;
            sgn_q  <= 1'b0;
            wr_q   <= 1'b0;
            err_q  <= 1'b0;
            data_o <= '0;
            err_o  <= 1'b0;
        end else begin
            state <= next_state;
            if (accept)
                cnt <= WAIT_M1;
            else if (state == ST_WAIT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (accept) begin
                hold_q <= rd_word;
                lane_q <= lane;
                size_q <= size_i;
                sgn_q  <= signed_i;
                wr_q   <= wr_i;
                err_q  <= req_err;
            end
            if (resp_load) begin
                data_o <= resp_data_next;
                err_o  <= resp_err_next;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept) next_state = (WAIT > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (cnt == 4'd0) next_state = ST_RESP;
            ST_RESP: next_state = accept ? ((WAIT > 0) ? ST_WAIT : ST_RESP) : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state != ST_WAIT);
        valid_o = (state == ST_RESP);
    end

endmodule

// File: tb/tb_mem_unit_sized.sv
// Directed bench for mem_unit_sized: a WAIT=2 instance for access semantics and
// reset behaviour, and a WAIT=0 instance for back-to-back throughput.
module tb_mem_unit_sized;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req, wr, sgn;
    logic [1:0]  size;
    logic [12:0] addr;
    logic [31:0] din;
    logic        ready, valid, err;
    logic [31:0] dout;

    logic        req0, wr0, sgn0;
    logic [1:0]  size0;
    logic [12:0] addr0;
    logic [31:0] din0;
    logic        ready0, valid0, err0;
    logic [31:0] dout0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] pat [4] = '{32'hA1B2C3D4, 32'h01020304, 32'hCAFEF00D, 32'h80000001};

    mem_unit_sized #(.DATA_W(32), .ADDR_W(13), .WAIT(2)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .ready_o(ready), .wr_i(wr),
        .size_i(size), .signed_i(sgn), .addr_i(addr), .data_i(din),
        .valid_o(valid), .data_o(dout), .err_o(err)
    );

    mem_unit_sized #(.DATA_W(32), .ADDR_W(13), .WAIT(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .ready_o(ready0), .wr_i(wr0),
        .size_i(size0), .signed_i(sgn0), .addr_i(addr0), .data_i(din0),
        .valid_o(valid0), .data_o(dout0), .err_o(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on the WAIT=2 instance; optionally pokes a store while busy.
    task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [12:0] a, input logic [31:0] d,
                          input logic [31:0] exp_d, input logic exp_e,
                          input logic poke, input string tag);
        @(negedge clk);
        req = 1'b1; wr = w; size = sz; sgn = sg; addr = a; din = d;
        @(posedge clk);
        #1;
        req = 1'b0; wr = 1'b0; size = 2'd0; sgn = 1'b0; addr = 13'h1FFF; din = 32'hFFFFFFFF;
        @(negedge clk);
        check({tag, "_rdy1"}, {31'b0, ready}, 32'd0);
        check({tag, "_vld1"}, {31'b0, valid}, 32'd0);
        if (poke) begin
            req = 1'b1; wr = 1'b1; size = 2'd2; addr = 13'h00C; din = 32'h0;
        end
        @(negedge clk);
        req = 1'b0; wr = 1'b0;
        check({tag, "_rdy2"}, {31'b0, ready}, 32'd0);
        check({tag, "_vld2"}, {31'b0, valid}, 32'd0);
        @(negedge clk);
        check({tag, "_vld3"}, {31'b0, valid}, 32'd1);
        check({tag, "_rdy3"}, {31'b0, ready}, 32'd1);
        check({tag, "_data"}, dout, exp_d);
        check({tag, "_err"},  {31'b0, err}, {31'b0, exp_e});
        @(negedge clk);
        check({tag, "_vld4"}, {31'b0, valid}, 32'd0);
        check({tag, "_hold"}, dout, exp_d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        req = 0; wr = 0; sgn = 0; size = 0; addr = 0; din = 0;
        req0 = 0; wr0 = 0; sgn0 = 0; size0 = 0; addr0 = 0; din0 = 0;

        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_err",   {31'b0, err},   32'd0);
        check("rst_data",  dout,           32'h0);
        check("rst_ready0", {31'b0, ready0}, 32'd1);
        check("rst_valid0", {31'b0, valid0}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_valid", {31'b0, valid}, 32'd0);
        check("idle_ready", {31'b0, ready}, 32'd1);

        access(1, 2'd2, 0, 13'h00C, 32'hDEADBEEF, 32'h0,        0, 0, "st_word");
        access(0, 2'd2, 0, 13'h00C, 32'h0,        32'hDEADBEEF, 0, 0, "ld_word");
        access(1, 2'd0, 0, 13'h00D, 32'h1234565A, 32'h0,        0, 0, "st_byte");
        access(0, 2'd2, 0, 13'h00C, 32'h0,        32'hDEAD5AEF, 0, 0, "ld_word2");
        access(0, 2'd0, 1, 13'h00F, 32'h0,        32'hFFFFFFDE, 0, 0, "ld_sbyte");
        access(0, 2'd0, 0, 13'h00F, 32'h0,        32'h000000DE, 0, 0, "ld_ubyte");
        access(0, 2'd1, 1, 13'h00E, 32'h0,        32'hFFFFDEAD, 0, 0, "ld_shalf");
        access(0, 2'd1, 0, 13'h00C, 32'h0,        32'h00005AEF, 0, 0, "ld_uhalf");
        access(0, 2'd0, 1, 13'h00C, 32'h0,        32'hFFFFFFEF, 0, 0, "ld_sbyte0");
        access(1, 2'd1, 0, 13'h00D, 32'hFFFFFFFF, 32'h0,        1, 0, "st_misalign");
        access(0, 2'd3, 0, 13'h008, 32'h0,        32'h0,        1, 0, "ld_dword");
        access(0, 2'd2, 0, 13'h00C, 32'h0,        32'hDEAD5AEF, 0, 1, "ld_after_err");
        access(0, 2'd2, 0, 13'h00C, 32'h0,        32'hDEAD5AEF, 0, 0, "ld_after_poke");

        // WAIT=0: four stores then four loads with req held continuously
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check($sformatf("b2b_vld%0d", k - 1), {31'b0, valid0}, 32'd1);
                check($sformatf("b2b_rdy%0d", k - 1), {31'b0, ready0}, 32'd1);
                check($sformatf("b2b_dat%0d", k - 1), dout0, (k - 1 < 4) ? 32'h0 : pat[k - 5]);
            end
            req0 = 1'b1; size0 = 2'd2; sgn0 = 1'b0;
            wr0 = (k < 4);
            addr0 = 13'((k % 4) * 4);
            din0 = (k < 4) ? pat[k] : 32'h0;
        end
        @(negedge clk);
        check("b2b_vld7", {31'b0, valid0}, 32'd1);
        check("b2b_dat7", dout0, pat[3]);
        check("b2b_err7", {31'b0, err0}, 32'd0);
        req0 = 1'b0; wr0 = 1'b0;
        @(negedge clk);
        check("b2b_end", {31'b0, valid0}, 32'd0);

        // Reset during WAIT drops the response but keeps the store
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 13'h010; din = 32'h11223344;
        @(posedge clk);
        #1;
        req = 1'b0; wr = 1'b0;
        @(negedge clk);
        check("rstw_busy", {31'b0, ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_vld", {31'b0, valid}, 32'd0);
        check("rstw_rdy", {31'b0, ready}, 32'd1);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rstw_novld%0d", k), {31'b0, valid}, 32'd0);
        end
        access(0, 2'd2, 0, 13'h010, 32'h0, 32'h11223344, 0, 0, "ld_post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
